// File: rtl/clk_freq_monitor.sv
// Measures the period and high time of a slow asynchronous signal in system clock
// cycles. Flags lock after LOCK_COUNT consecutive in-tolerance periods, and flags
// loss when no rising edge arrives within TIMEOUT cycles.
module clk_freq_monitor #(
  parameter int unsigned NOMINAL    = 500000,
  parameter int unsigned TOLERANCE  = 500,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic        sig_in,
  output logic [19:0] period,
  output logic [19:0] high_time,
  output logic        period_valid,
  output logic        locked,
  output logic        lost
);

  localparam int unsigned CW  = 20;
  localparam int unsigned PW  = CW + 1;
  localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);

  // Tolerance window bounds wrap the same way the 21-bit compare does.
  localparam logic [PW-1:0]  TOL_LO  = PW'(NOMINAL - TOLERANCE);
  localparam logic [PW-1:0]  TOL_HI  = PW'(NOMINAL + TOLERANCE);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [LCW-1:0] LC_MAX  = LCW'(LOCK_COUNT);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_MEAS = 1'b1
  } state_e;

  logic           s1_q, s2_q, d_q;
  logic           rise;
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  hcnt_q, hcnt_d;
  logic [CW-1:0]  period_q, period_d;
  logic [CW-1:0]  high_q, high_d;
  logic           pv_q, pv_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q, locked_d;
  logic           lost_q, lost_d;
  logic [PW-1:0]  cnt_p1;
  logic           in_tol;

  // Two-flop synchronizer plus a delay flop for edge detection.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      d_q  <= s2_q;
    end
  end

  assign rise   = s2_q & ~d_q;
  assign cnt_p1 = {1'b0, cnt_q} + PW'(1);
  assign in_tol = (cnt_p1 >= TOL_LO) && (cnt_p1 <= TOL_HI);

  // State and measurement registers.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state_q    <= S_WAIT;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period_q   <= '0;
      high_q     <= '0;
      pv_q       <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      pv_q       <= pv_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
    end
  end

  // Next-state: wait for a reference edge, then count until the next edge or timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    period_d   = period_q;
    high_d     = high_q;
    pv_d       = 1'b0;
    lock_cnt_d = lock_cnt_q;
    locked_d   = (lock_cnt_q == LC_MAX);
    lost_d     = lost_q;
    case (state_q)
      S_WAIT: begin
        cnt_d  = '0;
        hcnt_d = '0;
        if (rise) begin
          state_d = S_MEAS;
          lost_d  = 1'b0;
        end
      end
      S_MEAS: begin
        cnt_d  = cnt_q + CW'(1);
        hcnt_d = hcnt_q + CW'(d_q);
        if (rise) begin
          // A rise on the final timeout cycle still counts as a valid period.
          period_d = cnt_p1[CW-1:0];
          high_d   = hcnt_q;
          pv_d     = 1'b1;
          cnt_d    = '0;
          hcnt_d   = '0;
          lost_d   = 1'b0;
          if (!in_tol) begin
            lock_cnt_d = '0;
          end else if (lock_cnt_q < LC_MAX) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end else if (cnt_q == TO_LAST) begin
          state_d    = S_WAIT;
          cnt_d      = '0;
          hcnt_d     = '0;
          lost_d     = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor with scaled-down parameters. The reference model works
// per driven period: it knows when each rising edge was applied and how long the
// signal stayed high, and derives the outputs from those edge timestamps.
module tb_clk_freq_monitor;

  localparam int NOM = 200;
  localparam int TOL = 10;
  localparam int TO  = 400;
  localparam int LC  = 4;
  // Outputs react a fixed number of sample points after an edge is applied.
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_in;
  logic [19:0] period;
  logic [19:0] high_time;
  logic        period_valid;
  logic        locked;
  logic        lost;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit ref_m;
  int prev_len;
  int prev_hi;
  int exp_period;
  int exp_high;
  int lock_m;
  bit locked_m;
  bit lost_m;

  clk_freq_monitor #(
    .NOMINAL   (NOM),
    .TOLERANCE (TOL),
    .TIMEOUT   (TO),
    .LOCK_COUNT(LC)
  ) dut (
    .clk_50mhz   (clk),
    .reset       (reset),
    .sig_in      (sig_in),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .lost        (lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_outputs(input bit exp_pv);
    chk("period_valid", 32'(period_valid), 32'(exp_pv));
    chk("period",       32'(period),       32'(exp_period));
    chk("high_time",    32'(high_time),    32'(exp_high));
    chk("locked",       32'(locked),       32'(locked_m));
    chk("lost",         32'(lost),         32'(lost_m));
  endtask

  function automatic bit in_tol(input int len);
    return (len >= NOM - TOL) && (len <= NOM + TOL);
  endfunction

  task automatic model_reset();
    ref_m      = 1'b0;
    prev_len   = 0;
    prev_hi    = 0;
    exp_period = 0;
    exp_high   = 0;
    lock_m     = 0;
    locked_m   = 1'b0;
    lost_m     = 1'b0;
  endtask

  // Synchronous reset pulse with sig_in held low; all outputs must read zero.
  task automatic do_reset(input int n);
    sig_in = 1'b0;
    reset  = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) begin
      tick();
      check_outputs(1'b0);
    end
    reset = 1'b0;
    tick();
    check_outputs(1'b0);
  endtask

  // Apply one rising edge, hold high for hi cycles and low for lo cycles.
  // Legal lengths: hi>=3, lo>=3, and len<=TO or len>=TO+LAT.
  task automatic drive_period(input int hi, input int lo);
    int len;
    bit pv_here;
    bit to_here;
    int lock_new;
    len      = hi + lo;
    pv_here  = ref_m && (prev_len <= TO);
    to_here  = (len > TO);
    lock_new = lock_m;
    if (pv_here) begin
      if (!in_tol(prev_len)) lock_new = 0;
      else if (lock_m < LC)  lock_new = lock_m + 1;
    end
    sig_in = 1'b1;
    for (int j = 1; j <= len; j++) begin
      tick();
      if (j == LAT) begin
        if (pv_here) begin
          exp_period = prev_len;
          exp_high   = prev_hi;
        end
        lost_m = 1'b0;
        lock_m = lock_new;
      end
      if (j == LAT + 1) locked_m = (lock_m == LC);
      if (to_here && j == TO + LAT) begin
        lost_m   = 1'b1;
        locked_m = 1'b0;
        lock_m   = 0;
      end
      check_outputs(pv_here && (j == LAT));
      if (j == hi) sig_in = 1'b0;
    end
    ref_m    = !to_here;
    prev_len = len;
    prev_hi  = hi;
  endtask

  initial begin
    int len;
    int hi;
    int r;
    reset  = 1'b1;
    sig_in = 1'b0;
    model_reset();

    do_reset(3);

    // Nominal 50% duty: first valid on 2nd edge, lock after 4 valid periods.
    repeat (6) drive_period(NOM / 2, NOM / 2);

    // One period just outside tolerance drops lock; four good ones restore it.
    drive_period(105, 106);
    repeat (5) drive_period(100, 100);

    // Tolerance boundaries: 190 and 210 in, 189 out, then 211 out.
    drive_period(95, 95);
    drive_period(105, 105);
    drive_period(94, 95);
    drive_period(105, 106);
    drive_period(100, 100);

    // Random in-tolerance periods with random duty.
    repeat (6) begin
      len = int'($urandom_range(NOM + TOL, NOM - TOL));
      hi  = int'($urandom_range(len - 3, 3));
      drive_period(hi, len - hi);
    end

    // Stuck low after an edge: loss, then the next edge only restarts.
    drive_period(50, TO + 20);
    repeat (3) drive_period(100, 100);

    // Stuck high: loss as well.
    drive_period(TO + 10, 10);
    repeat (2) drive_period(100, 100);

    // Edge exactly on the last timeout cycle is a valid (out-of-tolerance) period.
    drive_period(200, TO - 200);
    drive_period(100, 100);
    drive_period(100, 100);

    // Reset in the middle of a measurement discards it.
    repeat (5) drive_period(100, 100);
    drive_period(80, 70);
    do_reset(2);
    repeat (3) drive_period(100, 100);

    // Random mix of good, bad and lost periods.
    repeat (20) begin
      r = int'($urandom_range(9, 0));
      if (r < 6)      len = int'($urandom_range(NOM + TOL + 5, NOM - TOL - 5));
      else if (r < 9) len = int'($urandom_range(TO, 6));
      else            len = int'($urandom_range(TO + 40, TO + LAT + 2));
      hi = int'($urandom_range(len - 3, 3));
      drive_period(hi, len - hi);
    end
    drive_period(100, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
